// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary conversion and default address width.
// Used by both the write-side and read-side pointer logic.
package fifo_pkg;

    localparam int FIFO_ADDRESS_SIZE = 3;

    // Operate on 32 bits; callers zero-extend and truncate to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin one-hot arbiter; search starts one past the last granted index.
// Grant is combinational; last index only moves when a grant is issued.
module round_robin_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    logic [IDX_W-1:0] last_q;
    logic             found;
    int               start;
    int               idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        start       = (int'(last_q) >= NUM_REQ - 1) ? 0 : int'(last_q) + 1;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = start + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && en_i && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDX_W'(idx);
            end
        end
    end

    // Resetting to the top index makes the first search begin at 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= IDX_W'(NUM_REQ - 1);
        end else if (found) begin
            last_q <= grant_idx_o;
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Write side of an async FIFO with round-robin arbitration among NUM_REQ writers.
// Optional almost-full flag enabled by defining FIFO_WRITE_ALMOST_FULL_EN.
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter int ADDRESS_SIZE = FIFO_ADDRESS_SIZE,
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8
`ifdef FIFO_WRITE_ALMOST_FULL_EN
    , parameter int ALMOST_FULL_LEVEL = 2**ADDRESS_SIZE - 1
`endif
) (
    input  logic                          write_clk_i,
    input  logic                          write_reset_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
    output logic [NUM_REQ-1:0]            grant_o,
    input  logic [ADDRESS_SIZE:0]         read_to_write_pointer_i,
    output logic                          write_en_o,
    output logic [ADDRESS_SIZE-1:0]       write_address_o,
    output logic [DATA_WIDTH-1:0]         write_data_o,
    output logic [ADDRESS_SIZE:0]         write_pointer_o,
`ifdef FIFO_WRITE_ALMOST_FULL_EN
    output logic                          almost_full_o,
`endif
    output logic                          full_o,
    output logic [ADDRESS_SIZE:0]         level_o
);

    localparam int PTR_W = ADDRESS_SIZE + 1;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Full when write Gray equals read Gray with its two top bits inverted.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (ADDRESS_SIZE - 1);

    logic [PTR_W-1:0]      bin_q, bin_d;
    logic [PTR_W-1:0]      wptr_q, gray_d;
    logic [PTR_W-1:0]      rq_bin;
    logic [PTR_W-1:0]      level_q, level_d;
    logic                  full_q, full_d;
    logic                  wen_q;
    logic [ADDRESS_SIZE-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [IDX_W-1:0]      grant_idx;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;

    round_robin_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk_i       (write_clk_i),
        .rst_i       (write_reset_i),
        .req_i       (req_i),
        .en_i        (!full_q && !write_reset_i),
        .grant_o     (grant_o),
        .grant_idx_o (grant_idx)
    );

    assign accept   = |grant_o;
    assign sel_data = data_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign bin_d    = bin_q + PTR_W'(accept);
    assign gray_d   = PTR_W'(bin2gray(32'(bin_d)));
    assign rq_bin   = PTR_W'(gray2bin(32'(read_to_write_pointer_i)));
    assign full_d   = (gray_d == (read_to_write_pointer_i ^ FULL_MASK));
    assign level_d  = bin_d - rq_bin;

    always_ff @(posedge write_clk_i) begin
        if (write_reset_i) begin
            bin_q   <= '0;
            wptr_q  <= '0;
            full_q  <= 1'b0;
            level_q <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            bin_q   <= bin_d;
            wptr_q  <= gray_d;
            full_q  <= full_d;
            level_q <= level_d;
            wen_q   <= accept;
            if (accept) begin
                waddr_q <= bin_q[ADDRESS_SIZE-1:0];
                wdata_q <= sel_data;
            end
        end
    end

`ifdef FIFO_WRITE_ALMOST_FULL_EN
    logic af_q;
    always_ff @(posedge write_clk_i) begin
        if (write_reset_i) af_q <= 1'b0;
        else               af_q <= (int'(level_d) >= ALMOST_FULL_LEVEL);
    end
    assign almost_full_o = af_q;
`endif

    assign write_en_o      = wen_q;
    assign write_address_o = waddr_q;
    assign write_data_o    = wdata_q;
    assign write_pointer_o = wptr_q;
    assign full_o          = full_q;
    assign level_o         = level_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (ADDRESS_SIZE=3, NUM_REQ=4, DATA_WIDTH=8).
// Almost-full scenario is compiled only with FIFO_WRITE_ALMOST_FULL_EN.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [3:0]  rq;
    logic        wen;
    logic [2:0]  waddr;
    logic [7:0]  wdata;
    logic [3:0]  wptr;
    logic        full;
    logic [3:0]  level;
`ifdef FIFO_WRITE_ALMOST_FULL_EN
    logic        afull;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .ADDRESS_SIZE (3),
        .NUM_REQ      (4),
        .DATA_WIDTH   (8)
`ifdef FIFO_WRITE_ALMOST_FULL_EN
        , .ALMOST_FULL_LEVEL (6)
`endif
    ) dut (
        .write_clk_i             (clk),
        .write_reset_i           (rst),
        .req_i                   (req),
        .data_i                  (data),
        .grant_o                 (grant),
        .read_to_write_pointer_i (rq),
        .write_en_o              (wen),
        .write_address_o         (waddr),
        .write_data_o            (wdata),
        .write_pointer_o         (wptr),
`ifdef FIFO_WRITE_ALMOST_FULL_EN
        .almost_full_o           (afull),
`endif
        .full_o                  (full),
        .level_o                 (level)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 4'b0000;
        rq  = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst  = 1'b1;
        req  = 4'b1111;
        rq   = 4'b0000;
        data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tick();
        tick();
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++;
        if ({wen, waddr, wdata, wptr, full, level} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs got wen=%b addr=%0d data=%h wptr=%b full=%b level=%0d exp=all 0",
                     wen, waddr, wdata, wptr, full, level);
        end
        rst = 1'b0;
    endtask

    task automatic test_fill;
        logic [3:0] eg;
        do_reset();
        req  = 4'b1111;
        data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 8; i++) begin
            #1;
            eg = 4'b0001 << (i % 4);
            checks++;
            if (grant !== eg) begin failures++; $display("FAIL fill_grant[%0d] got=%b exp=%b", i, grant, eg); end
            tick();
            checks++;
            if (wen !== 1'b1 || waddr !== 3'(i) || wdata !== 8'(8'hA0 + (i % 4)) ||
                level !== 4'(i + 1) || full !== (i == 7)) begin
                failures++;
                $display("FAIL fill_write[%0d] got wen=%b addr=%0d data=%h level=%0d full=%b exp 1/%0d/%h/%0d/%0d",
                         i, wen, waddr, wdata, level, full, i, 8'hA0 + (i % 4), i + 1, (i == 7));
            end
        end
        checks++;
        if (wptr !== 4'b1100) begin failures++; $display("FAIL fill_wptr got=%b exp=1100", wptr); end
        #1;
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("FAIL full_grant got=%b exp=0000", grant); end
        tick();
        checks++;
        if (wen !== 1'b0 || waddr !== 3'd7 || full !== 1'b1 || level !== 4'd8) begin
            failures++;
            $display("FAIL full_hold got wen=%b addr=%0d full=%b level=%0d exp 0/7/1/8", wen, waddr, full, level);
        end
    endtask

    // Continues from the full state left by test_fill.
    task automatic test_full_release;
        rq = 4'b0001;
        tick();
        checks++;
        if (full !== 1'b0 || level !== 4'd7) begin
            failures++;
            $display("FAIL release_flag got full=%b level=%0d exp 0/7", full, level);
        end
        #1;
        checks++;
        if (grant !== 4'b0001) begin failures++; $display("FAIL release_grant got=%b exp=0001", grant); end
        tick();
        checks++;
        if (wen !== 1'b1 || waddr !== 3'd0 || wdata !== 8'hA0 || full !== 1'b1 || level !== 4'd8 || wptr !== 4'b1101) begin
            failures++;
            $display("FAIL release_write got wen=%b addr=%0d data=%h full=%b level=%0d wptr=%b exp 1/0/a0/1/8/1101",
                     wen, waddr, wdata, full, level, wptr);
        end
        #1;
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("FAIL refull_grant got=%b exp=0000", grant); end
    endtask

    task automatic test_wrap;
        logic       saw_full;
        logic       bad;
        logic [4:0] b;
        do_reset();
        saw_full = 1'b0;
        bad      = 1'b0;
        req  = 4'b0100;
        data = {8'h00, 8'h5C, 8'h00, 8'h00};
        for (int i = 0; i < 16; i++) begin
            #1;
            if (grant !== 4'b0100) bad = 1'b1;
            tick();
            if (wen !== 1'b1 || waddr !== 3'(i % 8) || wdata !== 8'h5C || level !== 4'd1) bad = 1'b1;
            if (full) saw_full = 1'b1;
            if (i == 14) begin
                checks++;
                if (wptr !== 4'b1000) begin failures++; $display("FAIL wrap_wptr15 got=%b exp=1000", wptr); end
            end
            b  = 5'(i + 1);
            rq = 4'(b ^ (b >> 1));
        end
        checks++;
        if (wptr !== 4'b0000) begin failures++; $display("FAIL wrap_wptr0 got=%b exp=0000", wptr); end
        checks++;
        if (bad) begin failures++; $display("FAIL wrap_stream got=mismatch exp=grant 0100, level 1 each write"); end
        checks++;
        if (saw_full) begin failures++; $display("FAIL wrap_full got=1 exp=never"); end
    endtask

    task automatic test_simultaneous;
        do_reset();
        req  = 4'b0001;
        data = {8'h00, 8'h00, 8'h00, 8'h11};
        for (int i = 0; i < 5; i++) tick();
        req = 4'b0000;
        tick();
        checks++;
        if (level !== 4'd5) begin failures++; $display("FAIL simul_pre got level=%0d exp=5", level); end
        req = 4'b0001;
        rq  = 4'b0001;
        tick();
        checks++;
        if (wen !== 1'b1 || level !== 4'd5 || full !== 1'b0) begin
            failures++;
            $display("FAIL simul_level got wen=%b level=%0d full=%b exp 1/5/0", wen, level, full);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        req  = 4'b1111;
        data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tick();
        tick();
        tick();
        checks++;
        if (level !== 4'd3 || wdata !== 8'hA2) begin
            failures++;
            $display("FAIL mid_pre got level=%0d data=%h exp 3/a2", level, wdata);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("FAIL mid_grant got=%b exp=0000", grant); end
        tick();
        checks++;
        if ({wen, waddr, wdata, wptr, full, level} !== 21'd0) begin
            failures++;
            $display("FAIL mid_outputs got wen=%b addr=%0d data=%h wptr=%b full=%b level=%0d exp=all 0",
                     wen, waddr, wdata, wptr, full, level);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0001) begin failures++; $display("FAIL mid_next_grant got=%b exp=0001", grant); end
    endtask

`ifdef FIFO_WRITE_ALMOST_FULL_EN
    task automatic test_almost_full;
        do_reset();
        req = 4'b0001;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (afull !== (i >= 6) || level !== 4'(i)) begin
                failures++;
                $display("FAIL afull_rise[%0d] got af=%b level=%0d exp %0d/%0d", i, afull, level, (i >= 6), i);
            end
        end
        req = 4'b0000;
        rq  = 4'b0001;
        tick();
        checks++;
        if (afull !== 1'b0 || level !== 4'd5) begin
            failures++;
            $display("FAIL afull_fall got af=%b level=%0d exp 0/5", afull, level);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_full_release();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
`ifdef FIFO_WRITE_ALMOST_FULL_EN
        test_almost_full();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
